// File: rtl/mod113_pkg.sv
// Shared constants and types for the mod-113 chunk-LUT reduction blocks.
package mod113_pkg;
  localparam int N_BITS   = 500;
  localparam int CHUNK_W  = 6;
  localparam int MODULUS  = 113;
  localparam int RES_W    = 7;
  localparam int N_CHUNKS = (N_BITS + CHUNK_W - 1) / CHUNK_W;
  localparam int SEL_W    = 7;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  typedef logic [RES_W-1:0] residue_t;
endpackage

// File: rtl/mod113_add_reduce.sv
// Combinational modular add of two residues with a single conditional subtract.
module mod113_add_reduce
  import mod113_pkg::*;
(
  input  residue_t a,
  input  residue_t b,
  output residue_t sum,
  output logic     overflow_err
);
  localparam logic [RES_W:0] MOD_EXT = (RES_W+1)'(MODULUS);
  localparam residue_t       MOD_RES = RES_W'(MODULUS);

  logic [RES_W:0] w_sum;

  assign w_sum = {1'b0, a} + {1'b0, b};
  // Valid inputs keep the sum below 2*MODULUS, so one subtract suffices.
  assign sum = (w_sum >= MOD_EXT) ? RES_W'(w_sum - MOD_EXT) : w_sum[RES_W-1:0];
  assign overflow_err = (a >= MOD_RES) || (b >= MOD_RES);
endmodule

// File: rtl/mod113_chunk_sequencer.sv
// Serial mod-113 reducer: walks 84 six-bit chunks through a shared LUT bank, one per cycle.
// Accept-to-result 85 cycles; one operand in flight, result held until out_ready.
module mod113_chunk_sequencer
  import mod113_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N_BITS-1:0]   in_data,
  output logic [SEL_W-1:0]    lut_sel,
  output logic [CHUNK_W-1:0]  lut_chunk,
  input  logic [RES_W-1:0]    lut_res,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RES_W-1:0]    out_res,
  output logic                out_err
);
  localparam int              PAD_W    = N_CHUNKS*CHUNK_W - N_BITS;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CHUNKS - 1);

  state_t                       r_state;
  state_t                       w_next;
  logic [SEL_W-1:0]             r_cnt;
  residue_t                     r_acc;
  logic                         r_err;
  logic [N_BITS-1:0]            r_operand;

  logic [N_CHUNKS*CHUNK_W-1:0]  w_padded;
  logic [8:0]                   w_bitpos;
  logic [CHUNK_W-1:0]           w_chunk;
  residue_t                     w_sum;
  logic                         w_ovf;
  logic                         w_last;

  // Zero pad above bit 499 so the final chunk carries only two live bits.
  assign w_padded = {{PAD_W{1'b0}}, r_operand};
  assign w_bitpos = 9'(r_cnt) * 9'(CHUNK_W);
  assign w_chunk  = w_padded[w_bitpos +: CHUNK_W];
  assign w_last   = (r_cnt == LAST_SEL);

  mod113_add_reduce u_add_reduce (
    .a            (r_acc),
    .b            (lut_res),
    .sum          (w_sum),
    .overflow_err (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid)  w_next = RUN;
      RUN:     if (w_last)    w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_err     <= 1'b0;
      r_operand <= '0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_operand <= in_data;
          r_cnt     <= '0;
          r_acc     <= '0;
          r_err     <= 1'b0;
        end
        RUN: begin
          r_acc <= w_sum;
          r_err <= r_err | w_ovf;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    out_res   = (r_state == DONE) ? r_acc : '0;
    out_err   = (r_state == DONE) && r_err;
    lut_sel   = (r_state == RUN) ? r_cnt : '0;
    lut_chunk = (r_state == RUN) ? w_chunk : '0;
  end
endmodule

// File: doc/mod113_chunk_sequencer.md
Name: mod113_chunk_sequencer

Overview:
- Serial controller for the mod-113 reduction of a 500-bit operand, built around one shared 6-input chunk-LUT bank (positions 0..83).
- Each LUT position maps one 6-bit chunk to the 7-bit residue of chunk*2^(6*i) mod 113.
- Per operand, the block walks all 84 chunk positions, one per cycle. It presents the position index and chunk value to the bank and accumulates the returned residues modulo 113.
- It sits between the operand producer (valid/ready) and the residue consumer (valid/ready), replacing the fully parallel adder tree where area matters.

Parameters:
- N_BITS, 500, operand width.
- CHUNK_W, 6, bits per LUT input.
- MODULUS, 113, reduction modulus.
- RES_W, 7, residue width (clog2(MODULUS)).
- N_CHUNKS, 84, ceil(N_BITS/CHUNK_W); derived, not overridden.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand.
- in_data  in  N_BITS  operand.
- lut_sel  out  7  chunk position index 0..83 driven to the LUT bank mux.
- lut_chunk  out  CHUNK_W  chunk value at position lut_sel.
- lut_res  in  RES_W  residue returned by the bank, combinational in the same cycle.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_res  out  RES_W  operand mod 113.
- out_err  out  1  a lut_res >= MODULUS was seen during this operand.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, cnt=0, acc=0, err=0, operand reg=0.
- Reset outputs: in_ready=1, out_valid=0, out_res=0, out_err=0, lut_sel=0, lut_chunk=0.
- Reset takes effect from any state, including mid-RUN; the in-flight operand is discarded and no result is emitted.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data, cnt<=0, acc<=0, err<=0, go to RUN.
- RUN:
  - in_ready=0.
  - lut_sel=cnt; lut_chunk=operand[6*cnt +: 6].
  - For cnt=83 only bits 499:498 are valid; the upper 4 bits of lut_chunk are 0.
  - Each cycle: acc <= (acc + lut_res >= 113) ? acc + lut_res - 113 : acc + lut_res.
  - The sum uses an 8-bit intermediate; both inputs are < 113, so the sum is < 226 and one conditional subtract is sufficient.
  - If lut_res >= 113: err <= 1 (sticky for this operand). The add/reduce still applies, using the 8-bit sum and one subtract; the result is then undefined but the block must not hang.
  - cnt increments each cycle. When cnt==83 the final update applies, then state goes to DONE with cnt<=0.
- DONE:
  - out_valid=1; out_res=acc; out_err=err; all three are held stable until out_ready.
  - On out_valid&out_ready, go to IDLE.
  - in_ready stays 0 in DONE; no overlap between operands.
- Outside RUN: lut_sel=0 and lut_chunk=0, so the bank input is quiet.
- Latency: operand accepted at edge T; RUN occupies cycles T+1..T+84; out_valid is first high in the cycle after edge T+84. That is 85 cycles accept-to-result.
- Throughput: one operand per 86 cycles with out_ready held high.
- Back-to-back: an operand can be accepted at the edge right after the result handshake, since in_ready=1 in IDLE.
- in_valid is ignored outside IDLE; in_data need not be held after acceptance.
- in_valid and rst together: rst wins, and the operand is not accepted.

Decomposition:
- Package mod113_pkg holds:
  - MODULUS, RES_W, CHUNK_W, N_BITS, N_CHUNKS;
  - state enum {IDLE, RUN, DONE};
  - typedef residue_t (logic [RES_W-1:0]).
- Sub-module mod113_add_reduce: combinational, inputs a and b (residue_t), outputs sum (residue_t) and overflow_err. It is reused by the parallel tree variants.

Test Plan:
- Operand 0, bank model returns golden residues -> out_res=0, out_err=0; out_valid first high 85 cycles after acceptance.
- Operand 114 -> out_res=1. Operand 2^6 (chunk1=1, bank returns 64) -> out_res=64. Check that lut_sel steps 0..83 exactly once each.
- Operand with only bit 499 set -> the cnt=83 chunk is 6'b000010, upper pad is 0; out_res=2^499 mod 113 from the golden model.
- out_ready held low 10 cycles in DONE -> out_res/out_valid stable, in_ready=0, an offered in_valid is not accepted; the result is released on the first out_ready.
- Reset asserted at RUN cycle 40 -> next cycle IDLE, in_ready=1, out_valid=0; a fresh operand then completes with the correct residue.
- Bank model forced to return 120 at position 10 -> out_err=1 with out_valid; the next operand, with a correct bank, gives out_err=0.
